// File: rtl/tluh_pkg.sv
// tluh_pkg: shared TL-UH widths plus the host-arbiter state, FIFO entry type and beat helpers.
package tluh_pkg;

   localparam int TL_AW = 32;
   localparam int TL_DW = 32;
   localparam int TL_DBW = TL_DW / 8;
   localparam int TL_SZW = 3;
   localparam int TL_BEATSMAXW = 4;

   localparam int TL_ARB_MAXHOSTS = 8;
   localparam int TL_ARB_IDW = $clog2(TL_ARB_MAXHOSTS);

   typedef enum logic {ARB, BURST} tluh_arb_state_e;

   typedef struct packed {
      logic [TL_ARB_IDW-1:0]   id;
      logic [TL_BEATSMAXW-1:0] rsp_beats;
   } tluh_arb_entry_t;

   // A zero beat count means a single beat.
   function automatic logic [TL_BEATSMAXW-1:0] norm_beats(input logic [TL_BEATSMAXW-1:0] b);
      return (b == '0) ? TL_BEATSMAXW'(1) : b;
   endfunction

   function automatic logic [TL_ARB_IDW-1:0] next_id(input logic [TL_ARB_IDW-1:0] id, input int n);
      return (int'(id) == n - 1) ? '0 : id + 1'b1;
   endfunction

endpackage

// File: rtl/tluh_arb_id_fifo.sv
// tluh_arb_id_fifo: in-order FIFO of {owner id, response beats} for requests in flight.
module tluh_arb_id_fifo
   import tluh_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  tluh_arb_entry_t wdata_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output tluh_arb_entry_t head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   tluh_arb_entry_t mem_q [DEPTH];
   tluh_arb_entry_t mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic do_push, do_pop;

   assign full_o = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign head_o = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop = pop_i & ~empty_o;

   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tluh_host_arbiter.sv
// tluh_host_arbiter: shares one TL-UH host adapter among N_HOSTS requesters with burst lock and in-order response routing.
// Define TLUH_ARB_FIXED_PRIO_EN for fixed priority (host 0 highest) instead of round-robin.
module tluh_host_arbiter
   import tluh_pkg::*;
#(
   parameter int N_HOSTS = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [N_HOSTS-1:0]                        h_req_i,
   output logic [N_HOSTS-1:0]                        h_gnt_o,
   input  logic [N_HOSTS-1:0][TL_AW-1:0]             h_addr_i,
   input  logic [N_HOSTS-1:0]                        h_we_i,
   input  logic [N_HOSTS-1:0][TL_DW-1:0]             h_wdata_i,
   input  logic [N_HOSTS-1:0][TL_DBW-1:0]            h_be_i,
   input  logic [N_HOSTS-1:0][TL_SZW-1:0]            h_size_i,
   input  logic [N_HOSTS-1:0][1:0]                   h_op_i,
   input  logic [N_HOSTS-1:0][2:0]                   h_param_i,
   input  logic [N_HOSTS-1:0][TL_BEATSMAXW-1:0]      h_req_beats_i,
   input  logic [N_HOSTS-1:0][TL_BEATSMAXW-1:0]      h_rsp_beats_i,
   output logic [N_HOSTS-1:0]                        h_valid_o,
   output logic [TL_DW-1:0]                          h_rdata_o,
   output logic                                      h_err_o,
   output logic                                      m_req_o,
   output logic [TL_AW-1:0]                          m_addr_o,
   output logic                                      m_we_o,
   output logic [TL_DW-1:0]                          m_wdata_o,
   output logic [TL_DBW-1:0]                         m_be_o,
   output logic [TL_SZW-1:0]                         m_size_o,
   output logic [1:0]                                m_op_o,
   output logic [2:0]                                m_param_o,
   input  logic                                      m_gnt_i,
   input  logic                                      m_valid_i,
   input  logic [TL_DW-1:0]                          m_rdata_i,
   input  logic                                      m_err_i,
   output logic                                      spurious_o
);

   localparam int IDW = TL_ARB_IDW;

   tluh_arb_state_e state_q, state_d;
   logic [IDW-1:0] lock_id_q, lock_id_d, start, winner, sel, rsp_id;
   logic [TL_BEATSMAXW-1:0] beat_cnt_q, beat_cnt_d, rsp_cnt_q, rsp_cnt_d, req_beats_sel, rsp_beats_sel;
   logic spurious_q, spurious_d;
   logic req_sel, accept, last, push, pop, deliver, last_rsp, fifo_full, fifo_empty;
   tluh_arb_entry_t push_entry, head;

`ifdef TLUH_ARB_FIXED_PRIO_EN
   assign start = '0;
`else
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   assign start = rr_ptr_q;
   assign rr_ptr_d = (accept && last) ? next_id(sel, N_HOSTS) : rr_ptr_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_ptr_q <= '0;
      else rr_ptr_q <= rr_ptr_d;
   end
`endif

   // Scan from farthest to nearest so the host closest to start wins.
   always_comb begin
      winner = '0;
      for (int k = N_HOSTS - 1; k >= 0; k--)
         for (int i = 0; i < N_HOSTS; i++)
            if (i == (int'(start) + k) % N_HOSTS && h_req_i[i]) winner = IDW'(i);
   end

   assign sel = (state_q == BURST) ? lock_id_q : winner;

   always_comb begin
      req_sel = 1'b0;
      m_addr_o = '0;
      m_we_o = 1'b0;
      m_wdata_o = '0;
      m_be_o = '0;
      m_size_o = '0;
      m_op_o = '0;
      m_param_o = '0;
      req_beats_sel = '0;
      rsp_beats_sel = '0;
      for (int i = 0; i < N_HOSTS; i++)
         if (rst_ni && sel == IDW'(i)) begin
            req_sel = h_req_i[i];
            m_addr_o = h_addr_i[i];
            m_we_o = h_we_i[i];
            m_wdata_o = h_wdata_i[i];
            m_be_o = h_be_i[i];
            m_size_o = h_size_i[i];
            m_op_o = h_op_i[i];
            m_param_o = h_param_i[i];
            req_beats_sel = h_req_beats_i[i];
            rsp_beats_sel = h_rsp_beats_i[i];
         end
   end

   assign m_req_o = req_sel & ~fifo_full;
   assign accept = m_req_o & m_gnt_i;

   always_comb begin
      for (int i = 0; i < N_HOSTS; i++) h_gnt_o[i] = accept && sel == IDW'(i);
   end

   always_comb begin
      last = (state_q == BURST) ? beat_cnt_q <= TL_BEATSMAXW'(1) : norm_beats(req_beats_sel) == TL_BEATSMAXW'(1);
      state_d = (accept && last) ? ARB : (accept && state_q == ARB) ? BURST : state_q;
      lock_id_d = (accept && state_q == ARB) ? winner : lock_id_q;
      beat_cnt_d = !accept ? beat_cnt_q : (state_q == ARB) ? norm_beats(req_beats_sel) - 1'b1 : beat_cnt_q - 1'b1;
   end

   assign push = accept && state_q == ARB;
   assign push_entry = '{id: winner, rsp_beats: norm_beats(rsp_beats_sel)};

   tluh_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (push),
      .wdata_i(push_entry),
      .pop_i  (pop),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .head_o (head)
   );

   // Response routing: the head entry owns every beat until its count is used up.
   assign rsp_id = head.id;
   assign deliver = rst_ni & m_valid_i & ~fifo_empty;
   assign last_rsp = rsp_cnt_q >= head.rsp_beats - 1'b1;
   assign pop = deliver & last_rsp;
   assign rsp_cnt_d = !deliver ? rsp_cnt_q : last_rsp ? '0 : rsp_cnt_q + 1'b1;
   assign h_rdata_o = deliver ? m_rdata_i : '0;
   assign h_err_o = deliver & m_err_i;
   assign spurious_d = spurious_q | (m_valid_i & fifo_empty);
   assign spurious_o = spurious_q;

   always_comb begin
      for (int i = 0; i < N_HOSTS; i++) h_valid_o[i] = deliver && rsp_id == IDW'(i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB;
         lock_id_q <= '0;
         beat_cnt_q <= '0;
         rsp_cnt_q <= '0;
         spurious_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_id_q <= lock_id_d;
         beat_cnt_q <= beat_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
         spurious_q <= spurious_d;
      end
   end

endmodule
